// File: rtl/csync_decoder.sv
// Composite-sync receiver: recovers a flywheel hsync, vsync, horizontal position
// and a lock flag from an active-low XOR composite sync, paced by the pixel ce.
module csync_decoder #(
  parameter int LINE  = 128,
  parameter int HW    = 10,
  parameter int VMIN  = 32,
  parameter int TOL   = 2,
  parameter int LOCKN = 4,
  parameter int CW    = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          csync,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] hpos,
  output logic          locked
);

  localparam int            LW        = $clog2(LOCKN + 1);
  localparam logic [CW-1:0] RUN_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] HPOS_LAST = CW'(LINE - 1);
  localparam logic [CW-1:0] WIN_LO    = CW'(LINE - 1 - TOL);
  localparam logic [CW-1:0] WIN_HI    = CW'(TOL);
  localparam logic [CW-1:0] VRUN      = CW'(VMIN - 1);
  localparam logic [CW-1:0] HW_C      = CW'(HW);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCKN);

  logic          sync1;
  logic          c;
  logic          prev;
  logic [CW-1:0] run;
  logic [CW-1:0] run_n;
  logic [CW-1:0] hpos_n;
  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_n;
  logic          fall;
  logic          rise;
  logic          align;
  logic          in_win;
  logic          vsync_n;
  logic          locked_n;
  logic          hsync_n;

  // csync is asynchronous, so the synchroniser runs on every clock regardless of ce.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      c     <= 1'b1;
    end else begin
      sync1 <= csync;
      c     <= sync1;
    end
  end

  always_comb begin
    fall     = prev & ~c;
    rise     = ~prev & c;
    in_win   = (hpos >= WIN_LO) || (hpos < WIN_HI);
    run_n    = (run == RUN_MAX) ? run : run + CW'(1);
    vsync_n  = vsync;
    hpos_n   = (hpos == HPOS_LAST) ? '0 : hpos + CW'(1);
    lock_n   = lock_cnt;
    align    = fall & ~vsync;

    if (fall | rise) begin
      run_n = CW'(1);
    end

    // Only an unbroken run of one level can reach VMIN, so short pulses of
    // either polarity never toggle vsync.
    if ((c == prev) && (run == VRUN)) begin
      vsync_n = ~c;
    end

    if (align) begin
      hpos_n = '0;
      if (in_win) begin
        lock_n = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LW'(1);
      end else begin
        lock_n = '0;
      end
    end

    locked_n = (lock_n == LOCK_MAX);
    hsync_n  = locked_n & (hpos_n < HW_C);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev     <= 1'b1;
      run      <= '0;
      vsync    <= 1'b0;
      hpos     <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
      hsync    <= 1'b0;
    end else if (ce) begin
      prev     <= c;
      run      <= run_n;
      vsync    <= vsync_n;
      hpos     <= hpos_n;
      lock_cnt <= lock_n;
      locked   <= locked_n;
      hsync    <= hsync_n;
    end
  end

endmodule

// File: tb/tb_csync_decoder.sv
// Bench for csync_decoder: directed and random composite-sync lines, with a
// line-level reference model feeding a scoreboard that a monitor drains.
module tb_csync_decoder;

  localparam int LINE  = 128;
  localparam int HW    = 10;
  localparam int VMIN  = 32;
  localparam int TOL   = 2;
  localparam int LOCKN = 4;
  localparam int CW    = 8;
  localparam int RUN_SAT = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          ce;
  logic          csync;
  logic          hsync;
  logic          vsync;
  logic [CW-1:0] hpos;
  logic          locked;

  int n_checks = 0;
  int n_errors = 0;
  bit ce_en = 1'b1;
  int ce_cnt = 0;

  logic [CW+2:0] exp_q[$];

  csync_decoder #(
    .LINE(LINE), .HW(HW), .VMIN(VMIN), .TOL(TOL), .LOCKN(LOCKN), .CW(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ce(ce),
    .csync(csync),
    .hsync(hsync),
    .vsync(vsync),
    .hpos(hpos),
    .locked(locked)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ce is a one-clock pulse every 6 clocks; ce_en freezes the divider.
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clock);
      if (ce_en) begin
        ce_cnt = (ce_cnt == 5) ? 0 : ce_cnt + 1;
        ce = (ce_cnt == 0);
      end else begin
        ce = 1'b0;
      end
    end
  end

  // Reference model: csync seen two clocks late, then line rules applied per ce.
  bit m_h0, m_h1, m_prev, m_vsync, m_locked, m_hsync;
  bit m_c, m_fall, m_edge, m_newv;
  int m_run, m_hpos, m_cnt;
  logic [CW-1:0] m_hp;

  task automatic model_reset();
    m_h0 = 1; m_h1 = 1; m_prev = 1; m_vsync = 0; m_locked = 0; m_hsync = 0;
    m_run = 0; m_hpos = 0; m_cnt = 0;
  endtask

  initial model_reset();

  always @(posedge clock) begin
    if (reset) begin
      model_reset();
    end else begin
      m_c = m_h1;
      m_h1 = m_h0;
      m_h0 = csync;
      if (ce) begin
        m_fall = m_prev && !m_c;
        m_edge = (m_prev != m_c);
        if (m_edge) m_run = 1;
        else if (m_run < RUN_SAT) m_run = m_run + 1;
        m_newv = m_vsync;
        if (!m_edge && m_run == VMIN) m_newv = !m_c;
        if (m_fall && !m_vsync) begin
          if (m_hpos >= LINE - 1 - TOL || m_hpos < TOL)
            m_cnt = (m_cnt < LOCKN) ? m_cnt + 1 : LOCKN;
          else
            m_cnt = 0;
          m_hpos = 0;
        end else begin
          m_hpos = (m_hpos + 1) % LINE;
        end
        m_vsync = m_newv;
        m_prev = m_c;
      end
      m_locked = (m_cnt == LOCKN);
      m_hsync = m_locked && (m_hpos < HW);
      m_hp = m_hpos[CW-1:0];
      exp_q.push_back({m_hsync, m_vsync, m_hp, m_locked});
    end
  end

  // Monitor: after each active edge, compare the DUT against the oldest expectation.
  always @(negedge clock) begin
    logic [CW+2:0] e;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({hsync, vsync, hpos, locked} !== e) begin
        n_errors++;
        $display("[TB] FAIL out @%0t: got hsync=%b vsync=%b hpos=%0d locked=%b, want hsync=%b vsync=%b hpos=%0d locked=%b",
                 $time, hsync, vsync, hpos, locked, e[CW+2], e[CW+1], e[CW:1], e[0]);
      end
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic wait_ce(input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      @(posedge clock);
      while (!ce && t < 200) begin
        @(posedge clock);
        t++;
      end
      if (t >= 200) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL ce_timeout @%0t: got no ce within %0d clocks", $time, t);
      end
      @(negedge clock);
    end
  endtask

  task automatic apply_line(input int low, input int period, input bit skip);
    if (!skip) csync = 1'b0;
    wait_ce(low);
    csync = 1'b1;
    wait_ce(period - low);
  endtask

  // Aligns from idle, then checks lock appears exactly on the fifth fall.
  task automatic acquire_lock(input string tag);
    csync = 1'b1;
    wait_ce(40);
    for (int i = 0; i < 4; i++) apply_line(10, LINE, 1'b0);
    check_output({tag, "_prelock"}, locked, 0);
    csync = 1'b0;
    wait_ce(1);
    check_output({tag, "_locked"}, locked, 1);
    check_output({tag, "_hpos0"}, hpos, 0);
    check_output({tag, "_hsync"}, hsync, 1);
    wait_ce(9);
    csync = 1'b1;
    wait_ce(LINE - 10 - 1);
  endtask

  initial begin
    #1000000;
    n_checks++;
    n_errors++;
    $display("[TB] FAIL watchdog: got no completion, want finish before time limit");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    reset = 1'b1;
    csync = 1'b1;
    repeat (4) @(negedge clock);
    check_output("rst_hsync", hsync, 0);
    check_output("rst_vsync", vsync, 0);
    check_output("rst_hpos", hpos, 0);
    check_output("rst_locked", locked, 0);
    #3 reset = 1'b0;

    acquire_lock("p1");
    for (int i = 0; i < 2; i++) apply_line(10, LINE, 1'b0);
    check_output("p1_vsync", vsync, 0);

    // Three inverted lines of vertical sync, then normal lines again.
    csync = 1'b0;
    wait_ce(VMIN - 1);
    check_output("v_rise_early", vsync, 0);
    wait_ce(1);
    check_output("v_rise", vsync, 1);
    wait_ce(118 - VMIN);
    csync = 1'b1;
    wait_ce(10);
    for (int i = 0; i < 2; i++) apply_line(118, LINE, 1'b0);
    csync = 1'b0;
    wait_ce(10);
    csync = 1'b1;
    wait_ce(VMIN - 1);
    check_output("v_fall_early", vsync, 1);
    wait_ce(1);
    check_output("v_fall", vsync, 0);
    wait_ce(118 - VMIN);
    check_output("v_locked", locked, 1);
    for (int i = 0; i < 2; i++) apply_line(10, LINE, 1'b0);

    // Jitter within tolerance, then a short line that breaks lock.
    apply_line(10, 126, 1'b0);
    apply_line(10, 129, 1'b0);
    apply_line(10, LINE, 1'b0);
    check_output("jit_locked", locked, 1);
    apply_line(10, 100, 1'b0);
    csync = 1'b0;
    wait_ce(1);
    check_output("jit_unlock", locked, 0);
    check_output("jit_hpos0", hpos, 0);
    wait_ce(9);
    csync = 1'b1;
    wait_ce(LINE - 10 - 1);
    for (int i = 0; i < 3; i++) apply_line(10, LINE, 1'b0);
    csync = 1'b0;
    wait_ce(1);
    check_output("jit_relock", locked, 1);
    wait_ce(9);
    csync = 1'b1;
    wait_ce(LINE - 10 - 1);

    apply_line(10, LINE, 1'b1);
    apply_line(10, LINE, 1'b0);
    check_output("miss_locked", locked, 1);

    for (int i = 0; i < 16; i++) begin
      int per, low;
      bit skip;
      per  = $urandom_range(124, 132);
      low  = $urandom_range(4, 14);
      skip = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) per = $urandom_range(60, 110);
      apply_line(low, per, skip);
    end

    // ce held off while csync toggles; the pending fall lands on the next ce.
    for (int i = 0; i < 5; i++) apply_line(10, LINE, 1'b0);
    wait_ce(30);
    ce_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (i % 7 == 3) csync = ~csync;
    end
    csync = 1'b0;
    ce_en = 1'b1;
    wait_ce(1);
    check_output("gate_unlock", locked, 0);
    check_output("gate_hpos0", hpos, 0);
    wait_ce(9);
    csync = 1'b1;
    wait_ce(80);

    // Asynchronous reset in the middle of an hsync pulse.
    for (int i = 0; i < 5; i++) apply_line(10, LINE, 1'b0);
    csync = 1'b0;
    wait_ce(3);
    #3 reset = 1'b1;
    #1;
    check_output("ar_hsync", hsync, 0);
    check_output("ar_vsync", vsync, 0);
    check_output("ar_hpos", hpos, 0);
    check_output("ar_locked", locked, 0);
    exp_q.delete();
    csync = 1'b1;
    repeat (3) @(negedge clock);
    #3 reset = 1'b0;
    acquire_lock("ar");
    apply_line(10, LINE, 1'b0);

    repeat (4) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
